instr_encoder: RTL and testbench
================================

# instr_encoder

Assembles 32-bit MIPS instruction words from decoded fields, the inverse of the instruction decoder, and streams them with sequential addresses to the instruction-memory write port. It sits between the test/boot program loader and instruction memory. It accepts the same field set and `op_type` convention the decoder emits, so decode→encode round-trips are bit-exact. A small FIFO absorbs memory back-pressure.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `BASE_ADDR`, 32'h0000_0000: first write address after reset or flush.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `w_flush` input 1: synchronous; empties the FIFO and reloads the address to `BASE_ADDR`.
- `w_in_valid` input 1: request valid.
- `w_in_ready` output 1: equals `!full`.
- `w_class_2` input 2: 0 = SPECIAL (`op_type` = func), 1 = primary opcode, 2 = REGIMM (`op_type[4:0]` = rt code), 3 = illegal.
- `w_op_type_6` input 6: opcode, func or rt code, per `w_class_2`.
- `w_rs_addr_5`, `w_rt_addr_5`, `w_rd_addr_5`, `w_sh_amt_5` input 5 each: register and shift fields.
- `w_imm_val_16` input 16: immediate or branch offset.
- `w_target_26` input 26: jump target.
- `w_out_valid` output 1: FIFO not empty.
- `w_out_ready` input 1: memory accepts the word.
- `w_out_addr_32` output 32: byte address of the head word.
- `w_out_data_32` output 32: head encoded word.
- `w_err` output 1: sticky; set on an unsupported request; cleared only by reset or `w_flush`.

## Operation
- Input handshake: an accept occurs when `w_in_valid && w_in_ready`. The encoder is purely combinational and writes into the FIFO tail at that edge.
- Class 0, func ∈ {ADD, ADDU, SUB, SUBU, MULT, MULTU, DIV, DIVU, SLT, SLTU, SLLV, SRLV, SRAV, JR, JALR}: word = `{6'b0, rs, rt, rd, 5'b0, func}`.
- Class 0, func ∈ {SLL, SRL, SRA}: word = `{6'b0, 5'b0, rt, rd, shamt, func}`.
- Class 1, op ∈ {ADDIU, SLTI, SLTIU, ORI, XORI, LW, SW, LB, LBU, SB, BEQ, BNE, BGTZ, BLEZ}: word = `{op, rs, rt, imm}`.
- LUI: rs is forced to 0.
- J, JAL: word = `{op, target}`.
- Class 2: see Configuration.
- Any other class/op combination pushes `32'h0000_0000` (NOP) and sets `w_err`. The FIFO slot is still consumed so addresses stay aligned with the request count.
- Output handshake: a pop occurs when `w_out_valid && w_out_ready`. Each pop advances `w_out_addr_32` by 4, wrapping modulo 2^32.
- FIFO full: `w_in_ready` = 0. A simultaneous pop does not admit a push in the same cycle.
- FIFO empty: `w_out_valid` = 0; `w_out_addr_32` holds the next address.
- Same-cycle push and pop when neither full nor empty: both occur and the count is unchanged.
- `w_flush` has priority over same-cycle push and pop; both are discarded.

## Timing
- Reset values: `w_in_ready` = 1, `w_out_valid` = 0, `w_out_data_32` = 0, `w_out_addr_32` = `BASE_ADDR`, `w_err` = 0, FIFO count = 0, pointers = 0.
- Latency: a request accepted at edge N presents `w_out_valid` = 1 after edge N (one cycle) if the FIFO was empty.
- Throughput: one word per cycle when `w_out_ready` is held high.
- `w_out_data_32` and `w_out_addr_32` are stable while `w_out_valid && !w_out_ready`.
- Asserting `reset_n` low mid-stream clears all state immediately. In-flight words are lost.

## Configuration
- `ENCODER_REGIMM_EN` defined: class 2 with rt ∈ {BGEZ, BLTZ} encodes as `{6'b000001, rs, rt_code, imm}`.
- `ENCODER_REGIMM_EN` undefined: every class-2 request is unsupported, so it pushes NOP and sets `w_err`.

## Structure
- Class codes `CLASS_SPECIAL`, `CLASS_PRIMARY` and `CLASS_REGIMM` are added to the shared ISA code include.
- The encoder consumes the existing opcode, func and REGIMM constants from that include; no local copies.
- Sub-module `instr_fifo` is parameterised by `DEPTH` and width 32. It provides push, pop, flush, full, empty and head data.
- The top level holds the combinational encoder, the address counter and the error flag.

## Test plan
- ADDU rs=1 rt=2 rd=3 (class 0, func 0x21), `w_out_ready` = 1 → next cycle data `32'h0022_1821` at addr `BASE_ADDR`.
- ADDIU rs=1 rt=2 imm=5, then J target `26'h010_0000` → data `32'h2422_0005` @0, then `32'h0810_0000` @4.
- Hold `w_out_ready` = 0 and issue 5 requests → `w_in_ready` drops after the 4th. Release → 4 words drain at addrs 0, 4, 8, 12, then the 5th is accepted.
- Class 2, BGEZ rs=4, imm=3:
  - with `ENCODER_REGIMM_EN` → `32'h0481_0003`;
  - without it → `32'h0000_0000` and `w_err` = 1.
- Class 1, op `6'h3F` → NOP pushed and `w_err` = 1. Then `w_flush` → `w_err` = 0, FIFO empty, addr = `BASE_ADDR`.
- `reset_n` low with 3 words queued → `w_out_valid` = 0 and all outputs at reset values before the next edge.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared MIPS ISA codes for the instruction encoder: decode classes, opcodes,
// SPECIAL func codes and REGIMM rt codes, plus small format-classification helpers.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        CLASS_SPECIAL = 2'd0,
        CLASS_PRIMARY = 2'd1,
        CLASS_REGIMM  = 2'd2,
        CLASS_ILLEGAL = 2'd3
    } instr_class_e;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    // R-type with rs/rt/rd operands and a zero shamt field
    function automatic logic is_rtype_reg(input logic [5:0] func);
        case (func)
            FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
            FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
            FUNC_SLT, FUNC_SLTU, FUNC_SLLV, FUNC_SRLV,
            FUNC_SRAV, FUNC_JR, FUNC_JALR:             return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_rtype_shamt(input logic [5:0] func);
        case (func)
            FUNC_SLL, FUNC_SRL, FUNC_SRA: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        case (op)
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI,
            OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB,
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:          return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_regimm_branch(input logic [4:0] rt_code);
        case (rt_code)
            RT_BLTZ, RT_BGEZ: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Parameterised synchronous FIFO holding encoded words; push is refused when
// full (even with a same-cycle pop) and flush discards everything.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Storage is not reset, so an empty FIFO presents zero rather than stale data
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded MIPS fields into 32-bit words and streams them, with sequential
// byte addresses, to instruction memory. Define ENCODER_REGIMM_EN to support BGEZ/BLTZ.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        w_flush,
    input  logic        w_in_valid,
    output logic        w_in_ready,
    input  logic [1:0]  w_class_2,
    input  logic [5:0]  w_op_type_6,
    input  logic [4:0]  w_rs_addr_5,
    input  logic [4:0]  w_rt_addr_5,
    input  logic [4:0]  w_rd_addr_5,
    input  logic [4:0]  w_sh_amt_5,
    input  logic [15:0] w_imm_val_16,
    input  logic [25:0] w_target_26,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] w_out_addr_32,
    output logic [31:0] w_out_data_32,
    output logic        w_err
);

    instr_class_e in_class;
    logic [31:0]  enc_word;
    logic         enc_legal;
    logic         accept;
    logic         pop;
    logic         full;
    logic         empty;
    logic [31:0]  head_data;
    logic [31:0]  out_addr;
    logic         err_flag;

    assign in_class    = instr_class_e'(w_class_2);
    assign w_in_ready  = !full;
    assign w_out_valid = !empty;
    assign accept      = w_in_valid && w_in_ready;
    assign pop         = w_out_valid && w_out_ready;

    // Unsupported combinations fall through as a NOP with enc_legal low
    always_comb begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b0;
        case (in_class)
            CLASS_SPECIAL: begin
                if (is_rtype_reg(w_op_type_6)) begin
                    enc_word  = {OP_SPECIAL, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
                                 5'b0, w_op_type_6};
                    enc_legal = 1'b1;
                end else if (is_rtype_shamt(w_op_type_6)) begin
                    enc_word  = {OP_SPECIAL, 5'b0, w_rt_addr_5, w_rd_addr_5,
                                 w_sh_amt_5, w_op_type_6};
                    enc_legal = 1'b1;
                end
            end
            CLASS_PRIMARY: begin
                if (is_itype(w_op_type_6)) begin
                    enc_word  = {w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_imm_val_16};
                    enc_legal = 1'b1;
                end else if (w_op_type_6 == OP_LUI) begin
                    enc_word  = {OP_LUI, 5'b0, w_rt_addr_5, w_imm_val_16};
                    enc_legal = 1'b1;
                end else if ((w_op_type_6 == OP_J) || (w_op_type_6 == OP_JAL)) begin
                    enc_word  = {w_op_type_6, w_target_26};
                    enc_legal = 1'b1;
                end
            end
            CLASS_REGIMM: begin
`ifdef ENCODER_REGIMM_EN
                if (is_regimm_branch(w_op_type_6[4:0])) begin
                    enc_word  = {OP_REGIMM, w_rs_addr_5, w_op_type_6[4:0], w_imm_val_16};
                    enc_legal = 1'b1;
                end
`else
                enc_legal = 1'b0;
`endif
            end
            default: begin
                enc_word  = NOP_WORD;
                enc_legal = 1'b0;
            end
        endcase
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (w_flush),
        .push      (accept),
        .push_data (enc_word),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_data (head_data)
    );

    // Address tracks the head word; it advances only when memory takes a word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_addr <= BASE_ADDR;
        end else if (w_flush) begin
            out_addr <= BASE_ADDR;
        end else if (pop) begin
            out_addr <= out_addr + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_flag <= 1'b0;
        end else if (w_flush) begin
            err_flag <= 1'b0;
        end else if (accept && !enc_legal) begin
            err_flag <= 1'b1;
        end
    end

    assign w_out_addr_32 = out_addr;
    assign w_out_data_32 = head_data;
    assign w_err         = err_flag;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words/addresses are queued on accept
// and compared on each output handshake. Honours ENCODER_REGIMM_EN when defined.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clock        = 1'b0;
    logic        reset_n      = 1'b0;
    logic        w_flush      = 1'b0;
    logic        w_in_valid   = 1'b0;
    logic        w_out_ready  = 1'b0;
    logic [1:0]  w_class_2    = '0;
    logic [5:0]  w_op_type_6  = '0;
    logic [4:0]  w_rs_addr_5  = '0;
    logic [4:0]  w_rt_addr_5  = '0;
    logic [4:0]  w_rd_addr_5  = '0;
    logic [4:0]  w_sh_amt_5   = '0;
    logic [15:0] w_imm_val_16 = '0;
    logic [25:0] w_target_26  = '0;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [31:0] w_out_addr_32;
    logic [31:0] w_out_data_32;
    logic        w_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] push_addr = BASE;
    bit          exp_err   = 1'b0;
    int          n_cmp     = 0;
    int          n_err     = 0;

    instr_encoder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .w_flush       (w_flush),
        .w_in_valid    (w_in_valid),
        .w_in_ready    (w_in_ready),
        .w_class_2     (w_class_2),
        .w_op_type_6   (w_op_type_6),
        .w_rs_addr_5   (w_rs_addr_5),
        .w_rt_addr_5   (w_rt_addr_5),
        .w_rd_addr_5   (w_rd_addr_5),
        .w_sh_amt_5    (w_sh_amt_5),
        .w_imm_val_16  (w_imm_val_16),
        .w_target_26   (w_target_26),
        .w_out_valid   (w_out_valid),
        .w_out_ready   (w_out_ready),
        .w_out_addr_32 (w_out_addr_32),
        .w_out_data_32 (w_out_data_32),
        .w_err         (w_err)
    );

    always #5 clock = ~clock;

    // Reference encoding written straight from the MIPS field layouts
    function automatic void mdl(input logic [1:0] c, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [25:0] tgt,
                                output logic [31:0] w, output bit bad);
        w   = 32'h0;
        bad = 1'b1;
        if (c == 2'd0) begin
            if (op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h19, 6'h1A, 6'h1B,
                           6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09}) begin
                w = {6'b0, rs, rt, rd, 5'b0, op}; bad = 1'b0;
            end else if (op inside {6'h00, 6'h02, 6'h03}) begin
                w = {6'b0, 5'b0, rt, rd, sh, op}; bad = 1'b0;
            end
        end else if (c == 2'd1) begin
            if (op inside {6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h20,
                           6'h24, 6'h28, 6'h04, 6'h05, 6'h07, 6'h06}) begin
                w = {op, rs, rt, imm}; bad = 1'b0;
            end else if (op == 6'h0F) begin
                w = {op, 5'b0, rt, imm}; bad = 1'b0;
            end else if (op inside {6'h02, 6'h03}) begin
                w = {op, tgt}; bad = 1'b0;
            end
        end else if (c == 2'd2) begin
`ifdef ENCODER_REGIMM_EN
            if (op[4:0] inside {5'h00, 5'h01}) begin
                w = {6'b000001, rs, op[4:0], imm}; bad = 1'b0;
            end
`endif
        end
    endfunction

    task automatic set_req(input logic [1:0] c, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt);
        w_class_2 = c; w_op_type_6 = op; w_rs_addr_5 = rs; w_rt_addr_5 = rt;
        w_rd_addr_5 = rd; w_sh_amt_5 = sh; w_imm_val_16 = imm; w_target_26 = tgt;
        w_in_valid = 1'b1;
    endtask

    task automatic record_push();
        logic [31:0] w;
        bit          bad;
        exp_t        e;
        mdl(w_class_2, w_op_type_6, w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5,
            w_imm_val_16, w_target_26, w, bad);
        e.addr = push_addr;
        e.data = w;
        sb.push_back(e);
        push_addr = push_addr + 32'd4;
        if (bad) exp_err = 1'b1;
    endtask

    task automatic model_clear();
        sb.delete();
        push_addr = BASE;
        exp_err   = 1'b0;
    endtask

    // Used only while w_out_ready is low so no pop goes unobserved
    task automatic put_req(input logic [1:0] c, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt);
        set_req(c, op, rs, rt, rd, sh, imm, tgt);
        for (int k = 0; k < 16 && !w_in_ready; k++) @(negedge clock);
        if (!w_in_ready) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL put_req_timeout: w_in_ready=%b, expected 1", w_in_ready);
            w_in_valid = 1'b0;
            return;
        end
        record_push();
        @(negedge clock);
        w_in_valid = 1'b0;
    endtask

    task automatic do_flush();
        w_flush = 1'b1;
        @(negedge clock);
        w_flush = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        n_cmp++; if (w_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b expected 1", w_in_ready); end
        n_cmp++; if (w_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b expected 0", w_out_valid); end
        n_cmp++; if (w_out_data_32 !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h expected 0", w_out_data_32); end
        n_cmp++; if (w_out_addr_32 !== BASE) begin n_err++; $display("[TB] FAIL reset_addr: got %h expected %h", w_out_addr_32, BASE); end
        n_cmp++; if (w_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_err: got %b expected 0", w_err); end
    endtask

    task automatic test_special();
        exp_t e;
        w_out_ready = 1'b1;
        set_req(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        record_push();
        @(negedge clock);
        w_in_valid = 1'b0;
        n_cmp++; if (w_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL addu_latency: out_valid=%b expected 1", w_out_valid); end
        n_cmp++; if (w_out_data_32 !== 32'h0022_1821) begin n_err++; $display("[TB] FAIL addu_word: got %h expected 00221821", w_out_data_32); end
        e = sb.pop_front();
        n_cmp++; if (w_out_addr_32 !== e.addr) begin n_err++; $display("[TB] FAIL addu_addr: got %h expected %h", w_out_addr_32, e.addr); end
        @(negedge clock);
        n_cmp++; if (w_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL addu_drained: out_valid=%b expected 0", w_out_valid); end
        w_out_ready = 1'b0;
        put_req(2'd0, 6'h00, 5'd9,  5'd5,  5'd6,  5'd7,  16'h0, 26'h0);
        put_req(2'd0, 6'h03, 5'd0,  5'd17, 5'd18, 5'd31, 16'h0, 26'h0);
        put_req(2'd0, 6'h08, 5'd31, 5'd0,  5'd0,  5'd0,  16'h0, 26'h0);
        put_req(2'd0, 6'h19, 5'd8,  5'd9,  5'd0,  5'd0,  16'h0, 26'h0);
        w_out_ready = 1'b1;
        for (int k = 0; k < 32 && sb.size() > 0; k++) begin
            if (w_out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                    n_err++;
                    $display("[TB] FAIL special_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                end
            end
            @(negedge clock);
        end
        if (sb.size() > 0) begin n_cmp++; n_err++; $display("[TB] FAIL special_timeout: %0d words left, expected 0", sb.size()); sb.delete(); end
        w_out_ready = 1'b0;
    endtask

    task automatic test_primary();
        exp_t e;
        for (int b = 0; b < 2; b++) begin
            if (b == 0) begin
                put_req(2'd1, 6'h09, 5'd1,  5'd2,  5'd0, 5'd0, 16'h0005, 26'h0);
                put_req(2'd1, 6'h02, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0,    26'h010_0000);
                put_req(2'd1, 6'h0F, 5'd7,  5'd3,  5'd0, 5'd0, 16'hABCD, 26'h0);
                put_req(2'd1, 6'h2B, 5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0);
            end else begin
                put_req(2'd1, 6'h0D, 5'd4,  5'd5,  5'd0, 5'd0, 16'h00FF, 26'h0);
                put_req(2'd1, 6'h05, 5'd6,  5'd7,  5'd0, 5'd0, 16'h8001, 26'h0);
                put_req(2'd1, 6'h03, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0,    26'h3FF_FFFF);
                put_req(2'd1, 6'h24, 5'd10, 5'd11, 5'd0, 5'd0, 16'h0010, 26'h0);
            end
            w_out_ready = 1'b1;
            for (int k = 0; k < 32 && sb.size() > 0; k++) begin
                if (w_out_valid) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                        n_err++;
                        $display("[TB] FAIL primary_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                    end
                end
                @(negedge clock);
            end
            if (sb.size() > 0) begin n_cmp++; n_err++; $display("[TB] FAIL primary_timeout: %0d words left, expected 0", sb.size()); sb.delete(); end
            w_out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   k;
        int   acc_at;
        bit   take;
        do_flush();
        n_cmp++; if (w_out_addr_32 !== BASE || w_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_state: addr=%h valid=%b expected %h 0", w_out_addr_32, w_out_valid, BASE); end
        for (int i = 0; i < DEPTH; i++) begin
            put_req(2'd0, 6'h21, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 26'h0);
        end
        n_cmp++; if (w_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_ready: got %b expected 0", w_in_ready); end
        set_req(2'd1, 6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 16'h5A5A, 26'h0);
        @(negedge clock);
        n_cmp++; if (w_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_hold_ready: got %b expected 0", w_in_ready); end
        n_cmp++; if (w_out_data_32 !== sb[0].data || w_out_addr_32 !== sb[0].addr) begin n_err++; $display("[TB] FAIL stall_stable: data=%h addr=%h expected %h %h", w_out_data_32, w_out_addr_32, sb[0].data, sb[0].addr); end
        w_out_ready = 1'b1;
        k = 0;
        acc_at = -1;
        while (k < 40 && (sb.size() > 0 || w_in_valid)) begin
            if (w_out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                    n_err++;
                    $display("[TB] FAIL bp_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                end
            end
            take = w_in_valid && w_in_ready;
            if (take) begin
                record_push();
                acc_at = k;
            end
            @(negedge clock);
            if (take) w_in_valid = 1'b0;
            k++;
        end
        n_cmp++; if (acc_at != 1) begin n_err++; $display("[TB] FAIL bp_fifth_accept: accepted at cycle %0d expected 1", acc_at); end
        if (sb.size() > 0 || w_in_valid) begin n_cmp++; n_err++; $display("[TB] FAIL bp_timeout: %0d words left, expected 0", sb.size()); sb.delete(); w_in_valid = 1'b0; end
        w_out_ready = 1'b0;
    endtask

    task automatic test_regimm();
        exp_t e;
        logic [31:0] bgez_word;
`ifdef ENCODER_REGIMM_EN
        bgez_word = 32'h0481_0003;
`else
        bgez_word = 32'h0000_0000;
`endif
        put_req(2'd2, 6'h01, 5'd4, 5'd0, 5'd0, 5'd0, 16'h0003, 26'h0);
        n_cmp++; if (w_out_data_32 !== bgez_word) begin n_err++; $display("[TB] FAIL bgez_word: got %h expected %h", w_out_data_32, bgez_word); end
        n_cmp++; if (w_err !== exp_err) begin n_err++; $display("[TB] FAIL bgez_err: got %b expected %b", w_err, exp_err); end
        put_req(2'd2, 6'h00, 5'd9, 5'd0, 5'd0, 5'd0, 16'hFFF0, 26'h0);
        w_out_ready = 1'b1;
        for (int k = 0; k < 32 && sb.size() > 0; k++) begin
            if (w_out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                    n_err++;
                    $display("[TB] FAIL regimm_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                end
            end
            @(negedge clock);
        end
        if (sb.size() > 0) begin n_cmp++; n_err++; $display("[TB] FAIL regimm_timeout: %0d words left, expected 0", sb.size()); sb.delete(); end
        w_out_ready = 1'b0;
        do_flush();
        n_cmp++; if (w_err !== 1'b0) begin n_err++; $display("[TB] FAIL regimm_flush_err: got %b expected 0", w_err); end
    endtask

    task automatic test_illegal_flush();
        exp_t e;
        put_req(2'd1, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0);
        n_cmp++; if (w_err !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_err: got %b expected 1", w_err); end
        n_cmp++; if (w_out_data_32 !== 32'h0) begin n_err++; $display("[TB] FAIL illegal_nop: got %h expected 0", w_out_data_32); end
        put_req(2'd3, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0);
        put_req(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0);
        put_req(2'd1, 6'h0F, 5'd5, 5'd6, 5'd0, 5'd0, 16'hBEEF, 26'h0);
        w_out_ready = 1'b1;
        for (int k = 0; k < 32 && sb.size() > 0; k++) begin
            if (w_out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                    n_err++;
                    $display("[TB] FAIL illegal_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                end
            end
            @(negedge clock);
        end
        if (sb.size() > 0) begin n_cmp++; n_err++; $display("[TB] FAIL illegal_timeout: %0d words left, expected 0", sb.size()); sb.delete(); end
        w_out_ready = 1'b0;
        n_cmp++; if (w_err !== 1'b1) begin n_err++; $display("[TB] FAIL err_sticky: got %b expected 1", w_err); end
        put_req(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        set_req(2'd1, 6'h0D, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1111, 26'h0);
        w_flush     = 1'b1;
        w_out_ready = 1'b1;
        @(negedge clock);
        w_flush     = 1'b0;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
        model_clear();
        n_cmp++; if (w_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid: got %b expected 0", w_out_valid); end
        n_cmp++; if (w_err !== 1'b0) begin n_err++; $display("[TB] FAIL flush_err: got %b expected 0", w_err); end
        n_cmp++; if (w_out_addr_32 !== BASE) begin n_err++; $display("[TB] FAIL flush_addr: got %h expected %h", w_out_addr_32, BASE); end
        n_cmp++; if (w_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_ready: got %b expected 1", w_in_ready); end
    endtask

    task automatic test_reset_midstream();
        put_req(2'd0, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0);
        put_req(2'd1, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h0);
        put_req(2'd1, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h123_4567);
        n_cmp++; if (w_out_valid !== 1'b1 || w_err !== 1'b1) begin n_err++; $display("[TB] FAIL pre_reset: valid=%b err=%b expected 1 1", w_out_valid, w_err); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (w_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_valid: got %b expected 0", w_out_valid); end
        n_cmp++; if (w_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_ready: got %b expected 1", w_in_ready); end
        n_cmp++; if (w_out_data_32 !== 32'h0) begin n_err++; $display("[TB] FAIL midreset_data: got %h expected 0", w_out_data_32); end
        n_cmp++; if (w_out_addr_32 !== BASE) begin n_err++; $display("[TB] FAIL midreset_addr: got %h expected %h", w_out_addr_32, BASE); end
        n_cmp++; if (w_err !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_err: got %b expected 0", w_err); end
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k;
        int   idx;
        bit   take;
        w_out_ready = 1'b1;
        idx = 0;
        k   = 0;
        set_req(2'd0, 6'h21, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 16'h0, 26'h0);
        while (k < 40 && (idx < 8 || sb.size() > 0)) begin
            if (w_out_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (w_out_data_32 !== e.data || w_out_addr_32 !== e.addr) begin
                    n_err++;
                    $display("[TB] FAIL b2b_drain: data=%h addr=%h, expected data=%h addr=%h", w_out_data_32, w_out_addr_32, e.data, e.addr);
                end
            end
            take = w_in_valid && w_in_ready;
            if (take) record_push();
            @(negedge clock);
            k++;
            if (take) begin
                idx++;
                if (idx >= 8) begin
                    w_in_valid = 1'b0;
                end else if (idx % 3 == 1) begin
                    set_req(2'd1, 6'h0D, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 5'd0, 16'($urandom), 26'h0);
                end else if (idx % 3 == 2) begin
                    set_req(2'd0, 6'h02, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'h0, 26'h0);
                end else begin
                    set_req(2'd0, 6'h21, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 16'h0, 26'h0);
                end
            end
        end
        n_cmp++; if (k != 9) begin n_err++; $display("[TB] FAIL b2b_throughput: took %0d cycles expected 9", k); end
        n_cmp++; if (w_err !== exp_err) begin n_err++; $display("[TB] FAIL b2b_err: got %b expected %b", w_err, exp_err); end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        reset_n = 1'b1;
        @(negedge clock);
        test_special();
        test_primary();
        test_backpressure();
        test_regimm();
        test_illegal_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
